// File: rtl/note_sequencer.sv
// note_sequencer: records {octave,note} codes with tick-measured hold times and replays
// them with the original timing. Entry 0 is shadowed in a register so playback starts at once.
module note_sequencer #(
  parameter int DEPTH_LOG2 = 8,
  parameter int CODE_W     = 6,
  parameter int DUR_W      = 12,
  parameter int TICK_DIV   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CODE_W-1:0]     code_in,
  input  logic                  start_rec,
  input  logic                  start_pb,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic [CODE_W-1:0]     play_code,
  output logic [1:0]            state,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ENT_W = CODE_W + DUR_W;
  localparam logic [DIV_W-1:0]      DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]      DUR_MAX    = '1;
  localparam logic [DUR_W-1:0]      DUR_ONE    = DUR_W'(1);
  localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2} state_t;

  state_t                 state_reg;
  logic [DIV_W-1:0]       div_reg;
  logic [CODE_W-1:0]      open_code_reg;
  logic [DUR_W-1:0]       dur_reg;        // record: elapsed ticks, play: ticks remaining
  logic [DEPTH_LOG2-1:0]  idx_reg;
  logic [ENT_W-1:0]       head_reg;
  logic [ENT_W-1:0]       rd_data_reg;
  logic [CODE_W-1:0]      play_code_reg;
  logic [DEPTH_LOG2:0]    count_reg;
  logic                   overflow_reg;
  logic [ENT_W-1:0]       mem [DEPTH];

  logic                   tick;
  logic [DUR_W-1:0]       dur_sat;
  logic [DUR_W-1:0]       dur_commit;
  logic                   code_changed;
  logic                   wr_en;
  logic [DEPTH_LOG2-1:0]  wr_addr;
  logic [ENT_W-1:0]       wr_data;
  logic [DEPTH_LOG2:0]    count_inc;
  logic                   last_entry;
  logic [DEPTH_LOG2-1:0]  next_idx;

  assign tick         = (div_reg == DIV_LAST);
  assign dur_sat      = (tick && dur_reg != DUR_MAX) ? dur_reg + 1'b1 : dur_reg;
  assign dur_commit   = (dur_sat == '0) ? DUR_ONE : dur_sat;
  assign code_changed = (code_in != open_code_reg);
  // A stop commits only a non-empty entry; a code change always commits
  assign wr_en        = (state_reg == RECORD) &&
                        (stop ? (dur_sat != '0) : (!start_rec && code_changed));
  assign wr_addr      = count_reg[DEPTH_LOG2-1:0];
  assign wr_data      = {open_code_reg, dur_commit};
  assign count_inc    = count_reg + 1'b1;
  assign last_entry   = ({1'b0, idx_reg} == count_reg - 1'b1);
  assign next_idx     = last_entry ? '0 : idx_reg + 1'b1;

  // The entry after the current one is always being fetched, so advancing has no gap
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_reg <= mem[next_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      play_code_reg <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      div_reg       <= '0;
      idx_reg       <= '0;
      dur_reg       <= '0;
      open_code_reg <= '0;
      head_reg      <= '0;
    end else begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
      if (wr_en && wr_addr == '0) head_reg <= wr_data;

      if (stop && state_reg != IDLE) begin
        if (wr_en) begin
          count_reg <= count_inc;
          if (count_inc == COUNT_FULL) overflow_reg <= 1'b1;
        end
        state_reg     <= IDLE;
        play_code_reg <= '0;
      end else if (start_rec && !stop) begin
        state_reg     <= RECORD;
        count_reg     <= '0;
        overflow_reg  <= 1'b0;
        open_code_reg <= code_in;
        dur_reg       <= '0;
        div_reg       <= '0;
        play_code_reg <= code_in;
      end else if (start_pb && !stop && state_reg != RECORD && count_reg != '0) begin
        state_reg     <= PLAY;
        idx_reg       <= '0;
        play_code_reg <= head_reg[ENT_W-1:DUR_W];
        dur_reg       <= head_reg[DUR_W-1:0];
        div_reg       <= '0;
      end else begin
        unique case (state_reg)
          IDLE: play_code_reg <= '0;
          RECORD: begin
            play_code_reg <= code_in;
            if (code_changed) begin
              count_reg     <= count_inc;
              open_code_reg <= code_in;
              dur_reg       <= '0;
              div_reg       <= '0;
              if (count_inc == COUNT_FULL) begin
                overflow_reg  <= 1'b1;
                state_reg     <= IDLE;
                play_code_reg <= '0;
              end
            end else begin
              dur_reg <= dur_sat;
            end
          end
          PLAY: begin
            if (tick) begin
              if (dur_reg > DUR_ONE) begin
                dur_reg <= dur_reg - 1'b1;
              end else if (last_entry && !loop_en) begin
                state_reg     <= IDLE;
                play_code_reg <= '0;
              end else begin
                idx_reg       <= next_idx;
                play_code_reg <= rd_data_reg[ENT_W-1:DUR_W];
                dur_reg       <= rd_data_reg[DUR_W-1:0];
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign play_code = play_code_reg;
  assign state     = state_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed and randomized record/playback runs checked against a
// segment-level model (hold lengths -> entries -> per-cycle playback stream).
module tb_note_sequencer;
  localparam int DL2 = 2;
  localparam int CW = 6;
  localparam int DW = 4;
  localparam int TD = 4;
  localparam int DEPTH = 4;
  localparam int DMAX = 15;

  logic clk;
  logic rst = 1'b1;
  logic [CW-1:0] code_in = '0;
  logic start_rec = 1'b0;
  logic start_pb = 1'b0;
  logic stop = 1'b0;
  logic loop_en = 1'b0;
  logic [CW-1:0] play_code;
  logic [1:0] state;
  logic [DL2:0] count;
  logic overflow;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [CW-1:0] code;
    int            dur;
  } entry_t;

  entry_t        model_q[$];
  logic [CW-1:0] seg_code[$];
  int            seg_len[$];
  logic [CW-1:0] stream[$];

  note_sequencer #(.DEPTH_LOG2(DL2), .CODE_W(CW), .DUR_W(DW), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .start_rec(start_rec), .start_pb(start_pb),
    .stop(stop), .loop_en(loop_en), .play_code(play_code), .state(state), .count(count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ticks_of(input int cycles);
    return (cycles / TD > DMAX) ? DMAX : cycles / TD;
  endfunction

  // Record the segments in seg_code/seg_len, then stop (optionally with start_rec)
  task automatic do_record(input bit rec_with_stop);
    int  n;
    int  end_seg;
    bit  over;
    int  d;
    n = seg_code.size();
    end_seg = n;
    over = 1'b0;
    model_q.delete();
    for (int i = 0; i < n - 1 && !over; i++) begin
      d = ticks_of(seg_len[i]);
      model_q.push_back('{code: seg_code[i], dur: (d == 0) ? 1 : d});
      if (model_q.size() == DEPTH) begin
        over = 1'b1;
        end_seg = i + 1;
      end
    end
    if (!over) begin
      d = ticks_of(seg_len[n-1]);
      if (d > 0) model_q.push_back('{code: seg_code[n-1], dur: d});
      if (model_q.size() == DEPTH) over = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < seg_len[i]; c++) begin
        code_in = seg_code[i];
        start_rec = (i == 0 && c == 0);
        cyc();
        start_rec = 1'b0;
        if (i < end_seg) begin
          check("rec_state", state, 1);
          check("rec_play", play_code, seg_code[i]);
        end else if (i == end_seg && c == 0) begin
          check("ovf_state", state, 0);
          check("ovf_count", count, DEPTH);
          check("ovf_flag", overflow, 1);
          check("ovf_play", play_code, 0);
        end else begin
          check("post_ovf_state", state, 0);
          check("post_ovf_play", play_code, 0);
        end
      end
    end
    stop = 1'b1;
    start_rec = rec_with_stop;
    cyc();
    stop = 1'b0;
    start_rec = 1'b0;
    $display("record: %0d segments -> %0d entries, overflow %0d", n, model_q.size(), over);
    check("stop_state", state, 0);
    check("stop_play", play_code, 0);
    check("stop_count", count, model_q.size());
    check("stop_overflow", overflow, over);
  endtask

  task automatic build_stream();
    stream.delete();
    foreach (model_q[j])
      repeat (model_q[j].dur * TD) stream.push_back(model_q[j].code);
  endtask

  // One pass without looping; loop_en wiggles mid-run but is low at the final boundary
  task automatic play_once();
    int len;
    build_stream();
    len = stream.size();
    loop_en = 1'b0;
    start_pb = 1'b1;
    cyc();
    start_pb = 1'b0;
    for (int k = 0; k < len; k++) begin
      check("pb_play", play_code, stream[k]);
      check("pb_state", state, 2);
      loop_en = (k >= 1 && k < len - 2);
      cyc();
    end
    loop_en = 1'b0;
    $display("play_once: %0d cycles", len);
    check("pb_end_play", play_code, 0);
    check("pb_end_state", state, 0);
  endtask

  task automatic play_loop(input int m);
    int len;
    build_stream();
    len = stream.size();
    loop_en = 1'b1;
    start_pb = 1'b1;
    cyc();
    start_pb = 1'b0;
    for (int k = 0; k < m; k++) begin
      check("loop_play", play_code, stream[k % len]);
      check("loop_state", state, 2);
      if (k == m - 1) stop = 1'b1;
      cyc();
    end
    stop = 1'b0;
    loop_en = 1'b0;
    $display("play_loop: stopped after %0d cycles (period %0d)", m, len);
    check("loop_stop_play", play_code, 0);
    check("loop_stop_state", state, 0);
  endtask

  task automatic try_empty_play();
    start_pb = 1'b1;
    cyc();
    start_pb = 1'b0;
    $display("start_pb with empty buffer");
    check("empty_pb_state", state, 0);
    check("empty_pb_play", play_code, 0);
  endtask

  initial begin
    logic [CW-1:0] prev;
    logic [CW-1:0] c;
    int nseg;

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    $display("reset applied");
    check("rst_state", state, 0);
    check("rst_play", play_code, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;

    // Two-entry recording, single pass, then looping stopped mid-entry
    seg_code = '{6'o41, 6'o43};
    seg_len = '{12, 8};
    do_record(1'b0);
    check("e0_dur", model_q[0].dur, 3);
    check("e1_dur", model_q[1].dur, 2);
    play_once();
    play_loop(45);

    // Buffer overflow at the fourth commit
    seg_code = '{6'o11, 6'o22, 6'o33, 6'o44, 6'o55};
    seg_len = '{4, 4, 4, 4, 4};
    do_record(1'b0);
    play_once();

    // Saturated duration, stop beats start_rec
    seg_code = '{6'o25};
    seg_len = '{70};
    do_record(1'b1);
    play_once();

    // Reset in the middle of playback behaves as power-on reset
    loop_en = 1'b1;
    start_pb = 1'b1;
    cyc();
    start_pb = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    loop_en = 1'b0;
    $display("reset during playback");
    check("midrst_state", state, 0);
    check("midrst_play", play_code, 0);
    check("midrst_count", count, 0);
    check("midrst_overflow", overflow, 0);
    try_empty_play();

    // Empty recording (stop before first tick) leaves count at zero
    seg_code = '{6'o17};
    seg_len = '{1};
    do_record(1'b0);
    try_empty_play();

    // Randomized recordings
    for (int r = 0; r < 8; r++) begin
      nseg = $urandom_range(1, 3);
      seg_code.delete();
      seg_len.delete();
      prev = 6'($urandom_range(0, 63));
      for (int s = 0; s < nseg; s++) begin
        c = 6'($urandom_range(0, 63));
        if (s > 0 && c == prev) c = c + 6'd1;
        seg_code.push_back(c);
        seg_len.push_back($urandom_range(1, 30));
        prev = c;
      end
      do_record(1'($urandom_range(0, 1)));
      if (model_q.size() > 0) begin
        play_once();
        build_stream();
        play_loop($urandom_range(1, 3 * stream.size()));
      end else begin
        try_empty_play();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
